// File: rtl/cache_fill_if.sv
// Miss-handler bus: cache miss requests, main-memory read port and cache fill port.
// master: the fill arbiter; slave: caches and memory around it.
interface cache_fill_if;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic        fill_wr;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        fill_dcache;
  logic        fill_tag_wr;
  logic [15:0] fill_base;
  logic        fill_busy;
  logic        i_fill_done;
  logic        d_fill_done;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_wr, fill_word, fill_data, fill_dcache,
           fill_tag_wr, fill_base, fill_busy, i_fill_done, d_fill_done
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, fill_wr, fill_word, fill_data, fill_dcache,
           fill_tag_wr, fill_base, fill_busy, i_fill_done, d_fill_done
  );
endinterface

// File: rtl/cache_fill_arbiter.sv
// Shared I/D-cache miss handler: arbitrates for the memory read port, fetches an
// 8-word block through a pipelined memory and streams it into the selected cache.
// Optional build macro: CRITICAL_WORD_FIRST_EN (fetch the missed word first, wrapping).
module cache_fill_arbiter (
  input  logic         clk,
  input  logic         rst,
  cache_fill_if.master bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] BLK_WORDS = CNT_W'(8);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(7);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
  logic [ADDR_W-1:0] fill_base_q, fill_base_d;
  logic              fill_dcache_q, fill_dcache_d;
  logic [2:0]        start_q, start_d;

  logic              issuing;
  logic              accepting;
  logic [2:0]        issue_word;
  logic [2:0]        recv_word;
  logic [ADDR_W-1:0] sel_addr;

  // State and fill-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      issue_cnt_q   <= '0;
      recv_cnt_q    <= '0;
      fill_base_q   <= '0;
      fill_dcache_q <= 1'b0;
      start_q       <= '0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      recv_cnt_q    <= recv_cnt_d;
      fill_base_q   <= fill_base_d;
      fill_dcache_q <= fill_dcache_d;
      start_q       <= start_d;
    end
  end

  // Request/return qualifiers; returns map to offsets in issue order
  always_comb begin
    issuing    = (state_q == ST_FILL) && (issue_cnt_q < BLK_WORDS);
    accepting  = (state_q == ST_FILL) && bus.mem_data_valid && (recv_cnt_q < BLK_WORDS);
    issue_word = 3'(start_q + issue_cnt_q[2:0]);
    recv_word  = 3'(start_q + recv_cnt_q[2:0]);
    sel_addr   = bus.d_miss ? bus.d_miss_addr : bus.i_miss_addr;
  end

  // Next-state: D-cache wins ties; fill runs to completion once started
  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    recv_cnt_d    = recv_cnt_q;
    fill_base_d   = fill_base_q;
    fill_dcache_d = fill_dcache_q;
    start_d       = start_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.d_miss || bus.i_miss) begin
          fill_base_d   = sel_addr & 16'hFFF0;
          fill_dcache_d = bus.d_miss;
`ifdef CRITICAL_WORD_FIRST_EN
          start_d       = sel_addr[3:1];
`else
          start_d       = 3'd0;
`endif
          issue_cnt_d   = '0;
          recv_cnt_d    = '0;
          state_d       = ST_FILL;
        end
      end
      ST_FILL: begin
        if (issuing) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (accepting) begin
          recv_cnt_d = recv_cnt_q + CNT_W'(1);
          if (recv_cnt_q == LAST_WORD) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state; fill write path is combinational
  always_comb begin
    bus.mem_en      = issuing;
    bus.mem_addr    = issuing ? 16'(fill_base_q + {12'd0, issue_word, 1'b0}) : '0;
    bus.fill_wr     = accepting;
    bus.fill_word   = accepting ? recv_word : '0;
    bus.fill_data   = accepting ? bus.mem_data : '0;
    bus.fill_dcache = fill_dcache_q;
    bus.fill_base   = fill_base_q;
    bus.fill_busy   = (state_q != ST_IDLE);
    bus.fill_tag_wr = (state_q == ST_DONE);
    bus.i_fill_done = (state_q == ST_DONE) && !fill_dcache_q;
    bus.d_fill_done = (state_q == ST_DONE) && fill_dcache_q;
  end

endmodule
